cam_key_loader: RTL and testbench
=================================

# cam_key_loader

Serial key-load stage that sits directly upstream of the camouflaged c432 netlist and drives its gate-select inputs s_0..s_11. It accepts a key one bit at a time over a valid/ready handshake, checks an even-parity trailer, and applies the key atomically to its outputs only when the parity check passes. An optional one-way lock freezes the applied key until reset.

## Interface
- NUM_CELLS, default 6: number of camouflaged cells.
- CELL_W, default 2: select bits per cell; KEY_W = NUM_CELLS*CELL_W (12 by default), derived, not overridable.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  single-cycle pulse that begins a new key load.
- bit_valid  in  1  bit_data is valid this cycle.
- bit_data  in  1  serial key bit; LSB (s_0) first, then parity.
- bit_ready  out  1  registered; high only in state SHIFT.
- lock_req  in  1  request to freeze the applied key.
- s  out  KEY_W  applied key; s[i] drives s_i of the netlist, so s[2k+1:2k] is cell k.
- key_valid  out  1  s holds a parity-checked key.
- key_locked  out  1  lock is active.
- parity_err  out  1  the last completed load failed its parity check.
- bit_count  out  clog2(KEY_W+2)  number of bits accepted in the current load.

## Operation
- States: IDLE, SHIFT, CHECK, LOCKED.
- IDLE:
  - load_start -> SHIFT; clear shadow register, bit_count and parity_err.
  - lock_req while key_valid=1 -> LOCKED.
  - lock_req while key_valid=0 is ignored.
- SHIFT:
  - A bit is accepted when bit_valid & bit_ready.
  - While bit_count < KEY_W: shadow[bit_count] <= bit_data.
  - When bit_count = KEY_W: the accepted bit is the parity bit.
  - bit_count increments on every accepted bit. On acceptance of the parity bit -> CHECK.
- CHECK (one cycle):
  - Pass condition: XOR of shadow and parity bit = 0 (even parity).
  - On pass: s <= shadow, key_valid <= 1, parity_err <= 0.
  - On fail: parity_err <= 1; s and key_valid unchanged.
  - Either way -> IDLE.
- LOCKED: load_start, bit_valid and lock_req are all ignored; bit_ready=0. Only rst_n exits this state.
- s and key_valid keep their previous values throughout SHIFT, so the netlist sees either the old key or the new one, never a partial key.
- load_start during SHIFT restarts the load: shadow and bit_count clear, and any bit_valid in the same cycle is discarded.
- load_start and lock_req are ignored during CHECK.
- lock_req during SHIFT is ignored.
- If load_start and lock_req arrive together in IDLE, lock_req wins when key_valid=1.
- Reset (at any time, including mid-load):
  - state IDLE
  - s=0, key_valid=0, key_locked=0, parity_err=0
  - bit_ready=0, bit_count=0
  - shadow cleared

## Timing
- load_start sampled at edge t -> bit_ready=1 from t+1.
- Bits are accepted one per cycle at most. Gaps in bit_valid are allowed and insert no penalty beyond the gap itself.
- Parity bit accepted at edge c:
  - state=CHECK and bit_ready=0 after c.
  - s, key_valid and parity_err update at edge c+1.
  - Back in IDLE after c+1.
- Minimum load time: 1 + KEY_W+1 + 1 cycles (15 cycles at default parameters).
- lock_req sampled in IDLE with key_valid=1 at edge t -> key_locked=1 from t+1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Good key: load_start, then bits of 12'hA5C LSB-first (0,0,1,1,1,0,1,0,0,1,0,1) followed by parity 0, back-to-back -> 2 cycles after the parity bit: s=12'hA5C, key_valid=1, parity_err=0; 15 cycles total.
- Bad parity: same key with parity bit 1 -> parity_err=1; s and key_valid keep their prior values (0/0 after reset, or 12'hA5C/1 after a previous good load).
- Lock: after a good load of 12'hA5C, pulse lock_req -> key_locked=1. A subsequent load_start plus 13 bits of 12'h3FF/parity 0 -> bit_ready stays 0 and s stays 12'hA5C.
- Restart and backpressure: accept 5 bits, pulse load_start together with bit_valid, then send 12'h3FF/parity 0 with one idle cycle between each bit -> bit_count restarts at 0, the bit sent with load_start is discarded, and the final s=12'h3FF.
- Reset mid-load: assert rst_n low after 7 accepted bits with key_valid=1 and s=12'hA5C -> all outputs 0 immediately. After release, a full good load of 12'h001 with parity 1 -> s=12'h001.
- Ignored lock: lock_req issued while key_valid=0 and also during SHIFT -> key_locked stays 0 in both cases.

Source files
------------

// File: rtl/cam_key_loader.sv
// ---------------------------------------------------------------------------
// cam_key_loader
//
// Serial key-load stage for the camouflaged c432 netlist. A key arrives one
// bit per accepted handshake, LSB (s_0) first, followed by an even-parity
// trailer bit. The key is collected in a shadow register and copied to the
// applied-key outputs in a single cycle, and only after the parity check
// passes. The netlist therefore sees either the old key or the new one,
// never a half-shifted mixture. An optional one-way lock freezes the applied
// key until the next reset.
//
// Parameters
//   NUM_CELLS  number of camouflaged cells (default 6)
//   CELL_W     select bits per cell (default 2)
//   KEY_W      derived: NUM_CELLS*CELL_W, must be at least 2
//
// Ports
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   load_start  in   single-cycle pulse, begins (or restarts) a key load
//   bit_valid   in   bit_data is valid this cycle
//   bit_data    in   serial key bit, then the parity bit
//   bit_ready   out  registered, high only while shifting key bits in
//   lock_req    in   request to freeze the applied key
//   s           out  applied key, s[2k+1:2k] selects cell k
//   key_valid   out  s holds a parity-checked key
//   key_locked  out  lock is active
//   parity_err  out  the last completed load failed its parity check
//   bit_count   out  number of bits accepted in the current load
// ---------------------------------------------------------------------------
module cam_key_loader #(
  parameter  int NUM_CELLS = 6,
  parameter  int CELL_W    = 2,
  localparam int KEY_W     = NUM_CELLS * CELL_W,
  localparam int CNT_W     = $clog2(KEY_W + 2)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_start,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  input  logic             lock_req,
  output logic [KEY_W-1:0] s,
  output logic             key_valid,
  output logic             key_locked,
  output logic             parity_err,
  output logic [CNT_W-1:0] bit_count
);

  // Width of an index into the shadow register. The counter runs one step
  // further than the key (it also counts the parity bit), so its low bits
  // are used as the index only while it is below KEY_W.
  localparam int IDX_W = $clog2(KEY_W);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SHIFT  = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_LOCKED = 2'd3;

  logic [1:0]       state;
  logic [KEY_W-1:0] shadow;
  logic             parity_bit;
  logic [IDX_W-1:0] shadow_idx;
  logic             accept;
  logic             key_bit;
  logic             parity_ok;

  assign shadow_idx = bit_count[IDX_W-1:0];

  // A bit is taken only when the loader advertised readiness. bit_ready is
  // itself only ever high in SHIFT, so this also blocks bits in every other
  // state without having to look at the state here.
  assign accept = bit_valid && bit_ready;

  // Distinguishes a key bit from the trailing parity bit.
  assign key_bit = (bit_count < CNT_W'(KEY_W));

  // Even parity: the XOR over the key and its trailer must come out zero.
  assign parity_ok = ~((^shadow) ^ parity_bit);

  // Control state machine. bit_ready is registered alongside the state so
  // it is set on entry to SHIFT and cleared on every way out of it; this
  // keeps the output free of any combinational path from the inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_ready  <= 1'b0;
      key_locked <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          // The lock takes priority over a simultaneous load_start, but only
          // once there is a checked key worth freezing.
          if (lock_req && key_valid) begin
            state      <= ST_LOCKED;
            key_locked <= 1'b1;
            bit_ready  <= 1'b0;
          end else if (load_start) begin
            state     <= ST_SHIFT;
            bit_ready <= 1'b1;
          end
        end
        ST_SHIFT: begin
          // A restart keeps us in SHIFT; only the parity bit moves on.
          if (!load_start && accept && !key_bit) begin
            state     <= ST_CHECK;
            bit_ready <= 1'b0;
          end
        end
        ST_CHECK: begin
          state     <= ST_IDLE;
          bit_ready <= 1'b0;
        end
        ST_LOCKED: begin
          // Sticky until reset: nothing on the inputs can leave this state.
          state     <= ST_LOCKED;
          bit_ready <= 1'b0;
        end
        default: begin
          state     <= ST_IDLE;
          bit_ready <= 1'b0;
        end
      endcase
    end
  end

  // Shadow register, parity trailer and bit counter. Both a fresh load from
  // IDLE and a restart in SHIFT wipe the partial key; on a restart any bit
  // presented in the same cycle is dropped rather than stored at index 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow     <= '0;
      parity_bit <= 1'b0;
      bit_count  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start && !(lock_req && key_valid)) begin
            shadow    <= '0;
            bit_count <= '0;
          end
        end
        ST_SHIFT: begin
          if (load_start) begin
            shadow    <= '0;
            bit_count <= '0;
          end else if (accept) begin
            if (key_bit) begin
              shadow[shadow_idx] <= bit_data;
            end else begin
              parity_bit <= bit_data;
            end
            bit_count <= bit_count + CNT_W'(1);
          end
        end
        default: begin
          shadow     <= shadow;
          parity_bit <= parity_bit;
          bit_count  <= bit_count;
        end
      endcase
    end
  end

  // Applied key and status flags. s and key_valid only ever change in the
  // single CHECK cycle, which is what makes the key update atomic from the
  // netlist's point of view. A failed check leaves the previous key in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s          <= '0;
      key_valid  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (load_start && !(lock_req && key_valid)) begin
            parity_err <= 1'b0;
          end
        end
        ST_CHECK: begin
          if (parity_ok) begin
            s          <= shadow;
            key_valid  <= 1'b1;
            parity_err <= 1'b0;
          end else begin
            parity_err <= 1'b1;
          end
        end
        default: begin
          s          <= s;
          key_valid  <= key_valid;
          parity_err <= parity_err;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cam_key_loader.sv
// ---------------------------------------------------------------------------
// tb_cam_key_loader
//
// Self-checking bench for cam_key_loader. Whole key loads are driven as
// transactions; the expected applied key and flags are worked out per load
// from the key value and its parity bit with plain arithmetic.
// ---------------------------------------------------------------------------
module tb_cam_key_loader;

  localparam int KEY_W = 12;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_start = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_data = 1'b0;
  logic             lock_req = 1'b0;
  logic             bit_ready;
  logic [KEY_W-1:0] s;
  logic             key_valid;
  logic             key_locked;
  logic             parity_err;
  logic [CNT_W-1:0] bit_count;

  int checks = 0;
  int failures = 0;

  // Reference state: what the netlist should currently be seeing.
  logic [KEY_W-1:0] exp_s = '0;
  logic             exp_kv = 1'b0;
  logic             exp_locked = 1'b0;
  logic             exp_perr = 1'b0;

  cam_key_loader dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .bit_valid  (bit_valid),
    .bit_data   (bit_data),
    .bit_ready  (bit_ready),
    .lock_req   (lock_req),
    .s          (s),
    .key_valid  (key_valid),
    .key_locked (key_locked),
    .parity_err (parity_err),
    .bit_count  (bit_count)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
    end
  endtask

  task automatic checkKeyState(input string tag);
    checkOutput({tag, "_s"}, 32'(s), 32'(exp_s));
    checkOutput({tag, "_key_valid"}, 32'(key_valid), 32'(exp_kv));
    checkOutput({tag, "_key_locked"}, 32'(key_locked), 32'(exp_locked));
    checkOutput({tag, "_parity_err"}, 32'(parity_err), 32'(exp_perr));
  endtask

  // Outcome of a completed load: even parity over key plus trailer passes.
  task automatic modelLoadDone(input logic [KEY_W-1:0] key, input logic par);
    if ((($countones(key) + int'(par)) % 2) == 0) begin
      exp_s    = key;
      exp_kv   = 1'b1;
      exp_perr = 1'b0;
    end else begin
      exp_perr = 1'b1;
    end
  endtask

  task automatic modelReset();
    exp_s      = '0;
    exp_kv     = 1'b0;
    exp_locked = 1'b0;
    exp_perr   = 1'b0;
  endtask

  // Shift key bits and the parity bit in, with random idle gaps and optional
  // random lock_req noise while shifting, then check the applied result.
  task automatic sendBits(input logic [KEY_W-1:0] key, input logic par,
                          input int gap_min, input int gap_max,
                          input bit lock_noise);
    int gap;
    for (int i = 0; i <= KEY_W; i++) begin
      gap = int'($urandom_range(gap_max, gap_min));
      repeat (gap) begin
        bit_valid = 1'b0;
        lock_req  = lock_noise ? 1'($urandom % 2) : 1'b0;
        tick();
      end
      bit_valid = 1'b1;
      bit_data  = (i < KEY_W) ? key[i] : par;
      lock_req  = lock_noise ? 1'($urandom % 2) : 1'b0;
      tick();
      bit_valid = 1'b0;
      lock_req  = 1'b0;
      checkOutput("bit_count_step", 32'(bit_count), 32'(i + 1));
      if (i < KEY_W) begin
        checkOutput("ready_in_shift", 32'(bit_ready), 32'd1);
        checkOutput("s_hold_shift", 32'(s), 32'(exp_s));
        checkOutput("lock_ignored_shift", 32'(key_locked), 32'd0);
      end
    end
    // CHECK cycle: not ready, key not yet applied.
    checkOutput("ready_in_check", 32'(bit_ready), 32'd0);
    checkOutput("s_hold_check", 32'(s), 32'(exp_s));
    tick();
    modelLoadDone(key, par);
    checkKeyState("after_load");
    checkOutput("ready_idle", 32'(bit_ready), 32'd0);
  endtask

  // A complete load starting from IDLE.
  task automatic applyStimulus(input logic [KEY_W-1:0] key, input logic par,
                               input int gap_max, input bit lock_noise);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    exp_perr   = 1'b0;
    checkOutput("ready_after_start", 32'(bit_ready), 32'd1);
    checkOutput("count_after_start", 32'(bit_count), 32'd0);
    checkKeyState("after_start");
    sendBits(key, par, 0, gap_max, lock_noise);
  endtask

  initial begin
    logic [KEY_W-1:0] rkey;
    logic             rpar;

    // Reset state.
    #2;
    modelReset();
    checkKeyState("reset");
    checkOutput("reset_ready", 32'(bit_ready), 32'd0);
    checkOutput("reset_count", 32'(bit_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // lock_req with no valid key is ignored.
    lock_req = 1'b1;
    tick();
    lock_req = 1'b0;
    checkOutput("lock_no_key", 32'(key_locked), 32'd0);
    checkOutput("lock_no_key_ready", 32'(bit_ready), 32'd0);

    // Bad parity right after reset: only the error flag moves.
    applyStimulus(12'hA5C, 1'b1, 0, 1'b0);
    // Good key back-to-back, 15 cycles from load_start to the applied key.
    applyStimulus(12'hA5C, 1'b0, 0, 1'b0);
    checkOutput("good_key", 32'(s), 32'hA5C);
    // Bad parity after a good key keeps the good key.
    applyStimulus(12'hA5C, 1'b1, 0, 1'b0);
    checkOutput("bad_keeps_key", 32'(s), 32'hA5C);
    // Good load with lock_req noise throughout SHIFT.
    applyStimulus(12'hA5C, 1'b0, 1, 1'b1);

    // Restart: 5 bits in, then load_start together with a bit.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'b1;
      tick();
    end
    checkOutput("restart_pre_count", 32'(bit_count), 32'd5);
    load_start = 1'b1;
    bit_valid  = 1'b1;
    bit_data   = 1'b1;
    tick();
    load_start = 1'b0;
    bit_valid  = 1'b0;
    checkOutput("restart_count", 32'(bit_count), 32'd0);
    checkOutput("restart_ready", 32'(bit_ready), 32'd1);
    sendBits(12'h3FF, 1'b0, 1, 1, 1'b0);
    checkOutput("restart_key", 32'(s), 32'h3FF);

    // Randomized loads with gaps, lock noise and occasional bad parity.
    for (int n = 0; n < 40; n++) begin
      rkey = KEY_W'($urandom);
      rpar = 1'(^rkey);
      if (($urandom % 4) == 0) rpar = ~rpar;
      applyStimulus(rkey, rpar, 2, 1'b1);
    end

    // Reset mid-load with a valid key applied.
    applyStimulus(12'hA5C, 1'b0, 0, 1'b0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bit_valid = 1'b1;
      bit_data  = 1'($urandom % 2);
      tick();
    end
    bit_valid = 1'b0;
    checkOutput("midload_count", 32'(bit_count), 32'd7);
    rst_n = 1'b0;
    #1;
    modelReset();
    checkKeyState("async_reset");
    checkOutput("async_reset_ready", 32'(bit_ready), 32'd0);
    checkOutput("async_reset_count", 32'(bit_count), 32'd0);
    #2;
    rst_n = 1'b1;
    tick();
    applyStimulus(12'h001, 1'b1, 0, 1'b0);
    checkOutput("after_reset_key", 32'(s), 32'h001);

    // Lock together with load_start: lock wins, then loads are ignored.
    applyStimulus(12'hA5C, 1'b0, 0, 1'b0);
    lock_req   = 1'b1;
    load_start = 1'b1;
    tick();
    lock_req   = 1'b0;
    load_start = 1'b0;
    exp_locked = 1'b1;
    checkKeyState("locked");
    checkOutput("locked_ready", 32'(bit_ready), 32'd0);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int i = 0; i <= KEY_W; i++) begin
      bit_valid = 1'b1;
      bit_data  = (i < KEY_W) ? 1'b1 : 1'b0;
      lock_req  = 1'($urandom % 2);
      tick();
      checkOutput("locked_ready_bits", 32'(bit_ready), 32'd0);
    end
    bit_valid = 1'b0;
    lock_req  = 1'b0;
    repeat (3) tick();
    checkKeyState("locked_after_load");
    checkOutput("locked_key", 32'(s), 32'hA5C);

    // Only reset leaves the lock.
    rst_n = 1'b0;
    #1;
    modelReset();
    checkKeyState("unlock_reset");
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
